// File: rtl/sar_pkg.sv
// sar_pkg: shared types for the successive-approximation search controller.
//   state_e      : controller states (idle, trial, verify, done)
//   flags_t      : comparator flag vector {equal, less, higher}
//   flags_onehot : true when exactly one comparator flag is asserted
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrial,
    StVerify,
    StDone
  } state_e;

  typedef struct packed {
    logic equal;
    logic less;
    logic higher;
  } flags_t;

  function automatic logic flags_onehot(input flags_t f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/sar_bit_ptr.sv
// sar_bit_ptr: bit pointer for the SAR search plus the trial-bit set/clear logic.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i        : start a search; pointer to MSB, next probe = MSB only
//   step_i        : resolve the current bit (keep_i) and arm the next lower bit
//   keep_i        : 1 keeps the pointer bit, 0 clears it
//   probe_i       : probe currently presented to the comparator
//   probe_next_o  : probe to present next cycle
//   last_o        : pointer is at bit 0 (final trial)
module sar_bit_ptr
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             keep_i,
  input  logic [WIDTH-1:0] probe_i,
  output logic [WIDTH-1:0] probe_next_o,
  output logic             last_o
);

  localparam int unsigned PtrW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(WIDTH - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d        = ptr_q;
    probe_next_o = probe_i;
    if (load_i) begin
      ptr_d                = PtrMax;
      probe_next_o         = '0;
      probe_next_o[PtrMax] = 1'b1;
    end else if (step_i) begin
      probe_next_o[ptr_q] = keep_i;
      if (ptr_q != '0) begin
        probe_next_o[ptr_q - 1'b1] = 1'b1;
        ptr_d                      = ptr_q - 1'b1;
      end
    end
  end

  assign last_o = (ptr_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= PtrMax;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation initiator driving the probe
// operand of a magnitude comparator and recovering the unknown target value.
//   CLK, RST      : clock, asynchronous active-high reset
//   START         : request a search (accepted only when idle)
//   EQUAL/LESS/HIGHER : comparator flags for PROBE vs target, sampled same cycle
//   PROBE         : registered trial value
//   BUSY          : high during trial and verify cycles
//   DONE          : one-cycle completion pulse
//   RESULT        : recovered value, held until the next completion
//   FOUND, ERROR  : completion status, valid with DONE and held afterwards
// Build option: define SAR_EARLY_EXIT_EN to finish as soon as a trial hits EQUAL;
// otherwise every search runs all WIDTH trials plus a verify cycle.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             EQUAL,
  input  logic             LESS,
  input  logic             HIGHER,
  output logic [WIDTH-1:0] PROBE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             FOUND,
  output logic             ERROR
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             error_q, error_d;

  flags_t           flags;
  logic             onehot;
  logic             load, step, keep;
  logic [WIDTH-1:0] probe_next;
  logic             last;

  assign flags  = '{equal: EQUAL, less: LESS, higher: HIGHER};
  assign onehot = flags_onehot(flags);
  // With one-hot flags, anything but HIGHER means the probe bit belongs to the target.
  assign keep   = ~HIGHER;

  sar_bit_ptr #(
    .WIDTH(WIDTH)
  ) u_bit_ptr (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (load),
    .step_i      (step),
    .keep_i      (keep),
    .probe_i     (probe_q),
    .probe_next_o(probe_next),
    .last_o      (last)
  );

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          load    = 1'b1;
          probe_d = probe_next;
          busy_d  = 1'b1;
          state_d = StTrial;
        end
      end
      StTrial: begin
        busy_d = 1'b1;
        if (!onehot) begin
          state_d  = StDone;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = probe_q;
          found_d  = 1'b0;
          error_d  = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
        end else if (EQUAL) begin
          state_d  = StDone;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = probe_q;
          found_d  = 1'b1;
          error_d  = 1'b0;
`endif
        end else begin
          step    = 1'b1;
          probe_d = probe_next;
          if (last) begin
            state_d = StVerify;
          end
        end
      end
      StVerify: begin
        state_d  = StDone;
        done_d   = 1'b1;
        result_d = probe_q;
        found_d  = EQUAL & onehot;
        error_d  = ~onehot;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  assign PROBE  = probe_q;
  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign FOUND  = found_q;
  assign ERROR  = error_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: self-checking bench for sar_search_ctrl (WIDTH=4) with a
// behavioural comparator and a binary-search reference model.
module tb_sar_search_ctrl;

  localparam int W = 4;
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         EQUAL, LESS, HIGHER;
  logic [W-1:0] PROBE, RESULT;
  logic         BUSY, DONE, FOUND, ERROR;

  logic [W-1:0] target = '0;
  logic         force_bad = 1'b0;

  int tests = 0;
  int fails = 0;
  int prev_res = 0, prev_fnd = 0, prev_err = 0;
  int dut_done_cycle;
  int dut_probes[1:W];

  always #5 CLK = ~CLK;

  sar_search_ctrl #(
    .WIDTH(W)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .EQUAL (EQUAL),
    .LESS  (LESS),
    .HIGHER(HIGHER),
    .PROBE (PROBE),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .RESULT(RESULT),
    .FOUND (FOUND),
    .ERROR (ERROR)
  );

  // Responder: behavioural magnitude comparator, optionally forced to EQUAL+HIGHER.
  always_comb begin
    if (force_bad) begin
      EQUAL  = 1'b1;
      LESS   = 1'b0;
      HIGHER = 1'b1;
    end else begin
      EQUAL  = (PROBE == target);
      LESS   = (PROBE < target);
      HIGHER = (PROBE > target);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One search. t: target during trials; tv: target during verify; bad: trial
  // (1-based) whose flags are forced non-one-hot, 0 for none; noise: extra START
  // pulses while busy and in the completion cycle.
  task automatic run_search(input int t, input int tv, input int bad, input bit noise);
    int probes[1:W];
    int r, p, stop_k, done_c, last_p, e_res, e_fnd, e_err;
    r = 0;
    stop_k = 0;
    e_res = 0; e_fnd = 0; e_err = 0;
    // Reference: plain binary search over the target's bits, MSB first.
    for (int k = 1; k <= W; k++) begin
      if (stop_k == 0) begin
        p = r | (1 << (W - k));
        probes[k] = p;
        if (k == bad) begin
          stop_k = k; e_res = p; e_fnd = 0; e_err = 1;
        end else if (EarlyExit && p == t) begin
          stop_k = k; e_res = p; e_fnd = 1; e_err = 0;
        end else if (p <= t) begin
          r = p;
        end
      end
    end
    if (stop_k != 0) begin
      done_c = stop_k + 1;
      last_p = probes[stop_k];
    end else begin
      done_c = W + 2;
      last_p = r;
      e_res  = r;
      e_fnd  = (r == tv) ? 1 : 0;
      e_err  = 0;
    end

    dut_done_cycle = -1;
    @(negedge CLK);
    START  = 1'b1;
    target = W'(t);
    for (int c = 1; c <= done_c + 2; c++) begin
      @(negedge CLK);
      if (c < done_c) begin
        chk($sformatf("busy c%0d t%0d", c, t), BUSY, 1);
        chk($sformatf("done c%0d t%0d", c, t), DONE, 0);
        chk($sformatf("probe c%0d t%0d", c, t), PROBE, (c <= W) ? probes[c] : r);
        chk($sformatf("held result c%0d t%0d", c, t), RESULT, prev_res);
      end else begin
        chk($sformatf("busy c%0d t%0d", c, t), BUSY, 0);
        chk($sformatf("done c%0d t%0d", c, t), DONE, (c == done_c) ? 1 : 0);
        chk($sformatf("probe c%0d t%0d", c, t), PROBE, last_p);
        chk($sformatf("result c%0d t%0d", c, t), RESULT, e_res);
        chk($sformatf("found c%0d t%0d", c, t), FOUND, e_fnd);
        chk($sformatf("error c%0d t%0d", c, t), ERROR, e_err);
      end
      if (DONE && dut_done_cycle < 0) dut_done_cycle = c;
      if (c <= W) dut_probes[c] = PROBE;
      START     = (noise && ((c < done_c && (c == 2 || c == 4)) || c == done_c));
      target    = (c == W + 1) ? W'(tv) : W'(t);
      force_bad = (c == bad);
    end
    START     = 1'b0;
    force_bad = 1'b0;
    target    = W'(t);
    prev_res  = e_res;
    prev_fnd  = e_fnd;
    prev_err  = e_err;
  endtask

  initial begin
    int t, tv, bad;
    bit noise;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("rst probe", PROBE, 0);
    chk("rst busy", BUSY, 0);
    chk("rst done", DONE, 0);
    chk("rst result", RESULT, 0);
    chk("rst found", FOUND, 0);
    chk("rst error", ERROR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // T=11 clean search.
    run_search(11, 11, 0, 1'b0);
    chk("t11 probe1", dut_probes[1], 8);
    chk("t11 probe2", dut_probes[2], 12);
    chk("t11 probe3", dut_probes[3], 10);
    chk("t11 probe4", dut_probes[4], 11);
    chk("t11 done cycle", dut_done_cycle, EarlyExit ? 5 : 6);
    chk("t11 result", RESULT, 11);
    chk("t11 found", FOUND, 1);
    chk("t11 error", ERROR, 0);

    // T=0: every trial HIGHER, verify at 0.
    run_search(0, 0, 0, 1'b0);
    chk("t0 probe1", dut_probes[1], 8);
    chk("t0 probe4", dut_probes[4], 1);
    chk("t0 done cycle", dut_done_cycle, 6);
    chk("t0 result", RESULT, 0);
    chk("t0 found", FOUND, 1);

    // T=0, target moves to 3 during verify.
    run_search(0, 3, 0, 1'b0);
    chk("t0->3 done cycle", dut_done_cycle, 6);
    chk("t0->3 result", RESULT, 0);
    chk("t0->3 found", FOUND, 0);
    chk("t0->3 error", ERROR, 0);

    // Non-one-hot flags in the second trial.
    run_search(11, 11, 2, 1'b0);
    chk("bad done cycle", dut_done_cycle, 3);
    chk("bad result", RESULT, 12);
    chk("bad found", FOUND, 0);
    chk("bad error", ERROR, 1);

    // Spurious START pulses while busy and in the completion cycle.
    run_search(5, 5, 0, 1'b1);
    chk("noise result", RESULT, 5);

    // Asynchronous reset mid-search.
    @(negedge CLK);
    START  = 1'b1;
    target = W'(9);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("pre-rst busy", BUSY, 1);
    #1 RST = 1'b1;
    #1;
    chk("async rst busy", BUSY, 0);
    chk("async rst probe", PROBE, 0);
    chk("async rst result", RESULT, 0);
    chk("async rst found", FOUND, 0);
    chk("async rst error", ERROR, 0);
    @(negedge CLK);
    RST = 1'b0;
    prev_res = 0; prev_fnd = 0; prev_err = 0;
    @(negedge CLK);
    chk("post-rst busy", BUSY, 0);
    chk("post-rst done", DONE, 0);

    // Randomized searches.
    for (int i = 0; i < 40; i++) begin
      t     = int'($urandom_range(0, 15));
      tv    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : t;
      bad   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0;
      noise = 1'($urandom_range(0, 1));
      run_search(t, tv, bad, noise);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Sequential initiator that drives the probe operand of the existing subtract-based magnitude comparator (probe on PORTA, unknown target on PORTB) and reads back its EQUAL/LESS/HIGHER flags.
- Runs an MSB-first successive-approximation search to recover the target value in at most WIDTH trials.
- Sits beside comparator_4_bits; the comparator is the responder, this block the initiator.

Parameters:
- WIDTH, 4, operand width in bits; PROBE and RESULT are WIDTH bits; legal range 2..16.

Ports:
- CLK  in  1  single clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  request a search; accepted only in IDLE
- EQUAL  in  1  comparator flag, PROBE == target
- LESS  in  1  comparator flag, PROBE < target
- HIGHER  in  1  comparator flag, PROBE > target
- PROBE  out  WIDTH  registered trial value to comparator PORTA
- BUSY  out  1  high in TRIAL and VERIFY states
- DONE  out  1  one-cycle completion pulse
- RESULT  out  WIDTH  recovered value; held until the next completion
- FOUND  out  1  RESULT confirmed equal to target; valid with DONE, held after
- ERROR  out  1  flags were not one-hot during a sampled cycle; valid with DONE, held after

Behaviour:
- Reset (async, immediate): state IDLE, PROBE=0, RESULT=0, BUSY=0, DONE=0, FOUND=0, ERROR=0, bit pointer=WIDTH-1.
- States: IDLE, TRIAL, VERIFY, DONE; all outputs registered; flags are sampled combinationally in the same cycle PROBE is presented.
- IDLE:
  - START=1 -> TRIAL next edge with PROBE = 1<<(WIDTH-1), pointer=WIDTH-1.
  - PROBE keeps its last value while idle.
- TRIAL, one cycle per bit; sample flags at the edge:
  - Flags not exactly one-hot -> DONE, ERROR=1, FOUND=0, RESULT=PROBE.
  - EQUAL -> early exit, see Optional Feature.
  - LESS -> keep the pointer bit.
  - HIGHER -> clear the pointer bit.
  - If pointer>0, also set bit pointer-1 and decrement the pointer.
  - If pointer==0, go to VERIFY with the final PROBE.
- VERIFY, one cycle:
  - FOUND=EQUAL, RESULT=PROBE.
  - Non-one-hot flags -> ERROR=1, FOUND=0.
  - Go to DONE.
- DONE, one cycle: DONE=1, BUSY=0; go to IDLE.
- Latency: START sampled in cycle 0; DONE high in cycle WIDTH+2 worst case (cycle 6 for WIDTH=4). Early exit at trial k (1-based) puts DONE in cycle k+1.
- START while BUSY or in DONE is ignored; no queuing.
- RST mid-search aborts at once; RESULT/FOUND/ERROR return to 0.
- Target is assumed stable only during BUSY. Any change shows up as FOUND=0 in VERIFY; it is not otherwise detected.

Optional Feature:
- Macro SAR_EARLY_EXIT_EN.
- Defined: EQUAL in TRIAL -> DONE next edge with RESULT=PROBE, FOUND=1; remaining bits are skipped.
- Undefined: EQUAL is treated like LESS (bit kept). Every search runs all WIDTH trials plus VERIFY, giving fixed latency WIDTH+2.

Decomposition:
- Shared package sar_pkg: state enum (IDLE, TRIAL, VERIFY, DONE) and a flag-vector typedef {EQUAL, LESS, HIGHER} with a one-hot check function.
- One natural sub-module, sar_bit_ptr: pointer register plus trial-bit set/clear logic producing next PROBE and a last-bit flag.
- FSM and outputs stay in the top.

Test Plan (WIDTH=4, behavioural comparator model against target T):
- T=11, early exit on -> probes 8,12,10,11; DONE cycle 5; RESULT=11, FOUND=1, ERROR=0.
- T=11, early exit off -> same probes, VERIFY at 11, DONE cycle 6; RESULT=11, FOUND=1.
- T=0 -> probes 8,4,2,1 all HIGHER; VERIFY at 0; DONE cycle 6; RESULT=0, FOUND=1.
- T=0, T switched to 3 during VERIFY -> DONE cycle 6, RESULT=0, FOUND=0, ERROR=0.
- Force EQUAL=1 and HIGHER=1 in second trial -> DONE next cycle, ERROR=1, FOUND=0, RESULT=12.
- RST pulsed in cycle 2 of a search -> immediately BUSY=0, PROBE=0, RESULT=0. START pulses while BUSY in a fresh search -> ignored, exactly one DONE pulse.
